// File: rtl/wizard_mem_pkg.sv
// Shared types and defaults for the data memory responder.
package wizard_mem_pkg;

  // Responder handshake states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  // Default test-completion mailbox address.
  localparam logic [31:0] DefaultTohostAddr = 32'h0000_1000;

  // Request captured on accept; held until the response completes.
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Core-side request/response bus of the data memory responder.
interface data_mem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  // Core side: issues requests, consumes responses.
  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Responder side.
  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_ram.sv
// Single-port word RAM: synchronous byte-lane write, combinational read.
module dmem_ram #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk_i,
  input  logic                           we_i,
  input  logic [3:0]                     be_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [31:0]                    wdata_i,
  output logic [31:0]                    rdata_o
);

  // Contents survive reset on purpose, so no reset on the array.
  logic [31:0] mem_q [DEPTH_WORDS];

  // Byte-lane write.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder with a tohost mailbox and access-fault reporting.
module data_mem_responder
  import wizard_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] TOHOST_ADDR = DefaultTohostAddr
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus,
  output logic                 tohost_valid,
  output logic [31:0]          tohost_data
);

  localparam int unsigned AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  req_t        cur_req;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        tohost_valid_q, tohost_valid_d;
  logic [31:0] tohost_data_q, tohost_data_d;

  logic        accept;
  logic        enter_resp;
  logic        aligned;
  logic        hit_tohost;
  logic        in_range;
  logic        acc_err;
  logic        ram_we;
  logic [31:0] ram_rdata;

  assign accept     = bus.req_valid & (state_q == StIdle);
  assign enter_resp = (state_d == StResp) & (state_q != StResp);

  // With LATENCY=1 the access commits on the accept edge, before req_q is loaded,
  // so decode straight from the bus while idle.
  always_comb begin
    if (state_q == StIdle) begin
      cur_req.we    = bus.req_we;
      cur_req.be    = bus.req_be;
      cur_req.addr  = bus.req_addr;
      cur_req.wdata = bus.req_wdata;
    end else begin
      cur_req = req_q;
    end
  end

  // Address decode: misaligned always faults; mailbox wins over the range check.
  always_comb begin
    aligned    = (cur_req.addr[1:0] == 2'b00);
    hit_tohost = (cur_req.addr == TOHOST_ADDR);
    in_range   = (cur_req.addr[31:AW+2] == '0);
    acc_err    = ~aligned | (~hit_tohost & ~in_range);
    ram_we     = enter_resp & cur_req.we & aligned & ~hit_tohost & in_range & ~reset;
  end

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .be_i    (cur_req.be),
    .addr_i  (cur_req.addr[AW+1:2]),
    .wdata_i (cur_req.wdata),
    .rdata_o (ram_rdata)
  );

  // FSM state and latency counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: count down in WAIT, hold RESP until the core takes it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          cnt_d   = CntLoad;
          state_d = (LATENCY > 1) ? StWait : StResp;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = StResp;
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.req_ready = (state_q == StIdle);
    bus.rsp_valid = (state_q == StResp);
    bus.rsp_rdata = rsp_rdata_q;
    bus.rsp_err   = rsp_err_q;
    tohost_valid  = tohost_valid_q;
    tohost_data   = tohost_data_q;
  end

  // Datapath next state: capture request on accept, commit the access on RESP entry.
  always_comb begin
    req_d          = accept ? cur_req : req_q;
    rsp_err_d      = rsp_err_q;
    rsp_rdata_d    = rsp_rdata_q;
    tohost_valid_d = 1'b0;
    tohost_data_d  = tohost_data_q;
    if (enter_resp) begin
      rsp_err_d   = acc_err;
      rsp_rdata_d = '0;
      if (!cur_req.we && !acc_err) begin
        rsp_rdata_d = hit_tohost ? tohost_data_q : ram_rdata;
      end
      if (cur_req.we && aligned && hit_tohost) begin
        tohost_valid_d = 1'b1;
        tohost_data_d  = cur_req.wdata;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q          <= '0;
      rsp_err_q      <= 1'b0;
      rsp_rdata_q    <= '0;
      tohost_valid_q <= 1'b0;
      tohost_data_q  <= '0;
    end else begin
      req_q          <= req_d;
      rsp_err_q      <= rsp_err_d;
      rsp_rdata_q    <= rsp_rdata_d;
      tohost_valid_q <= tohost_valid_d;
      tohost_data_q  <= tohost_data_d;
    end
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter: DEPTH_WORDS, default 1024, number of 32-bit words in backing store (power of two).
REQ-002 Parameter: LATENCY, default 2, cycles from request accept to rsp_valid (legal range 1..15).
REQ-003 Parameter: TOHOST_ADDR, default 32'h0000_1000, test-completion mailbox address.
REQ-004 Port: clk  input  1  single clock; all state on rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: req_valid  input  1  core request present.
REQ-007 Port: req_ready  output  1  responder can accept a request.
REQ-008 Port: req_we  input  1  1 = write, 0 = read.
REQ-009 Port: req_be  input  4  byte enables for writes, bit i = byte lane i.
REQ-010 Port: req_addr  input  32  byte address.
REQ-011 Port: req_wdata  input  32  write data.
REQ-012 Port: rsp_valid  output  1  response present.
REQ-013 Port: rsp_ready  input  1  core accepts response.
REQ-014 Port: rsp_rdata  output  32  read data (0 for writes and errors).
REQ-015 Port: rsp_err  output  1  access fault flag, qualified by rsp_valid.
REQ-016 Port: tohost_valid  output  1  one-cycle pulse on mailbox write.
REQ-017 Port: tohost_data  output  32  last value written to mailbox.

Function
REQ-018 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 Accept = req_valid & req_ready; on accept, latch we/be/addr/wdata, load latency counter with LATENCY-1; next state WAIT if LATENCY>1, else RESP.
REQ-020 WAIT: decrement counter each cycle; transition to RESP when counter reaches 1, so rsp_valid rises exactly LATENCY cycles after the accept edge.
REQ-021 On entry to RESP, commit the access once: write updates only lanes with be=1; read captures word at addr[log2(DEPTH_WORDS)+1:2] into rsp_rdata.
REQ-022 RESP: rsp_valid=1; rsp_rdata and rsp_err held stable until rsp_valid & rsp_ready; then next state IDLE (no accept in the same cycle as response handshake).
REQ-023 addr[1:0] != 0 SHALL set rsp_err=1, suppress write, rsp_rdata=0.
REQ-024 Word-aligned addr beyond DEPTH_WORDS*4-1 and not equal to TOHOST_ADDR SHALL set rsp_err=1, no side effect.
REQ-025 Write to TOHOST_ADDR: rsp_err=0, tohost_data <= req_wdata (all lanes, be ignored), tohost_valid high for exactly the RESP-entry cycle; read of TOHOST_ADDR returns tohost_data.
REQ-026 Write with be=4'b0000 SHALL complete normally with no memory change.
REQ-027 req_* inputs SHALL be ignored outside IDLE; changes after accept do not affect the in-flight access.

Reset
REQ-028 reset asserted SHALL immediately force state IDLE, req_ready=1 after release, rsp_valid=0, rsp_err=0, rsp_rdata=0, tohost_valid=0, tohost_data=0, counter=0.
REQ-029 Reset during WAIT SHALL abandon the access with no memory write; reset during RESP SHALL drop the response without replay.
REQ-030 Backing store contents SHALL NOT be cleared by reset.

Structure
REQ-031 Package wizard_mem_pkg SHALL hold the state enum (IDLE/WAIT/RESP), default TOHOST_ADDR, and the latched-request struct (we, be, addr, wdata).
REQ-032 Storage SHALL be a sub-module dmem_ram: single-port, synchronous write with 4-lane byte enables, DEPTH_WORDS parameter.

Verification
REQ-033 Write 0xDEADBEEF to 0x10 be=4'hF, then read 0x10 -> rsp_valid 2 cycles after each accept, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-034 Write 0x000000AA to 0x10 be=4'b0001 after REQ-033 data -> read returns 0xDEADBEAA.
REQ-035 Read 0x12 and read 0x0000_4000 (DEPTH_WORDS=1024) -> rsp_err=1, rsp_rdata=0, memory unchanged.
REQ-036 Write 0x00000001 to 0x1000 -> tohost_valid single-cycle pulse, tohost_data=0x00000001, rsp_err=0.
REQ-037 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready=0 throughout; req_ready=1 the cycle after handshake.
REQ-038 Assert reset one cycle after a write accept to 0x20 -> all outputs zero immediately; subsequent read of 0x20 returns prior contents.
